seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter CLK_DIV, default 50000, clock cycles per digit slot (>= GHOST_CYC+2).
REQ-003 Parameter GHOST_CYC, default 2, cycles at start of each slot with all digits off.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  high = scanning; low = display dark.
REQ-007 load  input  1  one-cycle strobe capturing data_in, dp_in.
REQ-008 data_in  input  4*NUM_DIGITS  hex nibbles; nibble 0 (LSBs) = rightmost digit.
REQ-009 dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 lz_blank  input  1  high = leading-zero suppression on.
REQ-011 seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 dp_out  output  1  decimal point, active-low, registered.
REQ-013 dig_sel  output  NUM_DIGITS  digit enables, active-low one-cold, registered.
REQ-014 frame_done  output  1  one-cycle pulse when last digit slot ends.

Function
REQ-015 Slot counter SHALL count 0..CLK_DIV-1 and wrap; on wrap, digit index SHALL advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-016 load SHALL write data_in/dp_in into a shadow register; shadow SHALL copy into the active register only on the frame wrap cycle (index NUM_DIGITS-1 -> 0), preventing tearing.
REQ-017 load coincident with frame wrap SHALL transfer data_in/dp_in directly to active (bypass shadow) and also update shadow.
REQ-018 Decode: 0..9 standard (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000); A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 With lz_blank high, every digit above the highest nonzero nibble SHALL show 1111111 with dp off unless its dp bit is set; digit 0 SHALL never be suppressed.
REQ-020 While slot counter < GHOST_CYC, dig_sel SHALL be all ones and seg_out 1111111.
REQ-021 Otherwise dig_sel bit [index] SHALL be 0, others 1; seg_out/dp_out reflect active nibble [index]; outputs lag counter/index by exactly one cycle.
REQ-022 frame_done SHALL pulse on the cycle after the frame wrap, aligned with registered outputs.
REQ-023 enable low SHALL hold counter and index at 0, force dig_sel all ones, seg_out 1111111, dp_out 1, frame_done 0; load still captures into shadow and shadow SHALL copy to active while disabled.
REQ-024 enable rising SHALL start at digit 0, counter 0 (ghost interval first).

Reset
REQ-025 rst_n low SHALL asynchronously set seg_out 1111111, dp_out 1, dig_sel all ones, frame_done 0, counter 0, index 0, shadow and active registers 0.
REQ-026 Reset mid-frame SHALL discard pending shadow contents; first frame after release starts at digit 0.

Structure
REQ-027 Package seg_pkg SHALL hold the 16-entry segment code constants and the blank code 7'b1111111.
REQ-028 Sub-module seg_decode (4-bit nibble + blank flag -> 7-bit active-low code, combinational) SHALL be instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, CLK_DIV=4, GHOST_CYC=1)
REQ-029 Reset release, enable=1, load 16'h1234 -> after first frame wrap dig_sel cycles 1110,1101,1011,0111 showing 4,3,2,1 codes, each 3 cycles preceded by 1 dark cycle.
REQ-030 load 16'h00A5, lz_blank=1 -> digits 3,2 show 1111111; digit1 0001000; digit0 0010010.
REQ-031 load 16'hFFFF mid-frame -> displayed digits unchanged until frame wrap, then all 0001110; no mixed frame.
REQ-032 load 16'h0000 on frame-wrap cycle -> very next frame shows 1000000 on all digits (lz_blank=0).
REQ-033 enable dropped mid-slot -> next cycle dig_sel 1111, seg_out 1111111; re-enable restarts at digit 0 after 1 ghost cycle.
REQ-034 rst_n asserted mid-frame, asynchronous to clk -> outputs reset values immediately; frame_done stays 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0011000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Hex nibble to active-low segment pattern.
   function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
      logic [6:0] code;
      case (nib)
         4'h0:    code = SEG_0;
         4'h1:    code = SEG_1;
         4'h2:    code = SEG_2;
         4'h3:    code = SEG_3;
         4'h4:    code = SEG_4;
         4'h5:    code = SEG_5;
         4'h6:    code = SEG_6;
         4'h7:    code = SEG_7;
         4'h8:    code = SEG_8;
         4'h9:    code = SEG_9;
         4'hA:    code = SEG_A;
         4'hB:    code = SEG_B;
         4'hC:    code = SEG_C;
         4'hD:    code = SEG_D;
         4'hE:    code = SEG_E;
         default: code = SEG_F;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble decoder with a blank override.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      if (!blank) begin
         seg_c = seg_lookup(nibble);
      end
   end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display driver with ghost blanking, frame-synchronous
// data update and optional leading-zero suppression.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_DIV    = 50000,
   parameter int unsigned GHOST_CYC  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_blank,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_done
);

   localparam int unsigned DW = 4 * NUM_DIGITS;
   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [DW-1:0]         shadow_data;
   logic [DW-1:0]         active_data;
   logic [NUM_DIGITS-1:0] shadow_dp;
   logic [NUM_DIGITS-1:0] active_dp;

   logic                  slot_end_c;
   logic                  last_digit_c;
   logic                  frame_wrap_c;
   logic                  ghost_c;
   logic                  commit_c;
   logic                  zero_above_c;
   logic [3:0]            sel_nib_c;
   logic                  sel_dp_c;
   logic                  sel_blank_c;
   logic [NUM_DIGITS-1:0] dig_nxt_c;
   logic [6:0]            dec_seg_c;

   assign slot_end_c   = (cnt == CW'(CLK_DIV - 1));
   assign last_digit_c = (idx == IW'(NUM_DIGITS - 1));
   assign frame_wrap_c = enable && slot_end_c && last_digit_c;
   assign ghost_c      = (cnt < CW'(GHOST_CYC));
   // Active data may change only between frames, or freely while dark.
   assign commit_c     = frame_wrap_c || !enable;

   // Slot counter and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!enable) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end_c) begin
         cnt <= '0;
         idx <= last_digit_c ? '0 : idx + IW'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Shadow/active double buffer; a load on the commit cycle bypasses shadow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_data <= '0;
         shadow_dp   <= '0;
         active_data <= '0;
         active_dp   <= '0;
      end else begin
         if (load) begin
            shadow_data <= data_in;
            shadow_dp   <= dp_in;
         end
         if (commit_c) begin
            active_data <= load ? data_in : shadow_data;
            active_dp   <= load ? dp_in   : shadow_dp;
         end
      end
   end

   // Digit mux; scans from the top so each digit knows if all above it are zero.
   always_comb begin
      zero_above_c = 1'b1;
      sel_nib_c    = 4'h0;
      sel_dp_c     = 1'b0;
      sel_blank_c  = 1'b0;
      dig_nxt_c    = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above_c = zero_above_c && (active_data[4*i +: 4] == 4'h0);
         if (idx == IW'(i)) begin
            sel_nib_c    = active_data[4*i +: 4];
            sel_dp_c     = active_dp[i];
            sel_blank_c  = lz_blank && zero_above_c && (i != 0);
            dig_nxt_c[i] = 1'b0;
         end
      end
   end

   seg_decode u_decode (
      .nibble (sel_nib_c),
      .blank  (sel_blank_c),
      .seg_c  (dec_seg_c)
   );

   // Registered display outputs, one cycle behind counter/index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= SEG_BLANK;
         dp_out     <= 1'b1;
         dig_sel    <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_wrap_c;
         if (!enable || ghost_c) begin
            seg_out <= SEG_BLANK;
            dp_out  <= 1'b1;
            dig_sel <= '1;
         end else begin
            seg_out <= dec_seg_c;
            dp_out  <= ~sel_dp_c;
            dig_sel <= dig_nxt_c;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with 4 digits, 4-cycle slots, 1 ghost cycle.
module tb_seg_scan_display;

   localparam int unsigned ND = 4;
   localparam int unsigned CD = 4;
   localparam int unsigned GC = 1;
   localparam int FRAME = ND * CD;
   localparam logic [12:0] DARK = {1'b0, 4'b1111, 1'b1, 7'b1111111};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        lz_blank;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  dig_sel;
   logic        frame_done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [12:0] exp_q[$];

   always #5 clk = ~clk;

   seg_scan_display #(
      .NUM_DIGITS (ND),
      .CLK_DIV    (CD),
      .GHOST_CYC  (GC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .lz_blank   (lz_blank),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .dig_sel    (dig_sel),
      .frame_done (frame_done)
   );

   function automatic logic [6:0] hex_code(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0011000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Expected {frame_done, dig_sel, dp_out, seg_out} for frame positions first..first+n-1.
   task automatic push_slots(input logic [15:0] data, input logic [3:0] dp,
                             input logic lz, input int first, input int n);
      int h = 0;
      for (int i = 0; i < 4; i++) if (data[4*i +: 4] != 4'h0) h = i;
      for (int k = first; k < first + n; k++) begin
         int s = k % FRAME;
         int d = s / CD;
         int c = s % CD;
         logic [3:0] dig;
         logic [6:0] seg;
         logic       dpo;
         if (c < int'(GC)) begin
            dig = 4'b1111;
            dpo = 1'b1;
            seg = 7'b1111111;
         end else begin
            dig    = 4'b1111;
            dig[d] = 1'b0;
            dpo    = ~dp[d];
            seg    = (lz && d > h) ? 7'b1111111 : hex_code(data[4*d +: 4]);
         end
         exp_q.push_back({(s == FRAME - 1), dig, dpo, seg});
      end
   endtask

   task automatic push_dark(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(DARK);
   endtask

   task automatic wait_frame(output logic seen);
      seen = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         @(posedge clk); #1;
         seen = frame_done;
      end
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; lz_blank = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs = {frame_done, dig_sel, dp_out, seg_out};
      n_tests++;
      if (obs !== DARK) begin
         n_fail++; $display("FAIL reset_state: got %b want %b", obs, DARK);
      end
      rst_n = 1'b1;
      push_dark(3);
      for (int k = 0; k < 3; k++) begin
         logic [12:0] exp;
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL disabled_dark[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_scan();
      logic seen;
      logic [12:0] exp, obs;
      enable = 1'b1; load = 1'b1; data_in = 16'h1234; dp_in = 4'b0000;
      @(posedge clk); #1;
      load = 1'b0;
      wait_frame(seen);
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++; $display("FAIL scan_frame_done: got %b want 1", seen);
      end
      push_slots(16'h1234, 4'b0000, 1'b0, 0, 2 * FRAME);
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL scan[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_lz_blank();
      logic seen;
      logic [12:0] exp, obs;
      wait_frame(seen);
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++; $display("FAIL lz_frame_done: got %b want 1", seen);
      end
      push_slots(16'h1234, 4'b0000, 1'b1, 0, FRAME);
      push_slots(16'h00A5, 4'b1000, 1'b1, 0, FRAME);
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (k == 0) begin
            load = 1'b1; data_in = 16'h00A5; dp_in = 4'b1000; lz_blank = 1'b1;
         end
         @(posedge clk); #1;
         load = 1'b0;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL lz_blank[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_no_tearing();
      logic seen;
      logic [12:0] exp, obs;
      wait_frame(seen);
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++; $display("FAIL tear_frame_done: got %b want 1", seen);
      end
      lz_blank = 1'b0;
      push_slots(16'h00A5, 4'b1000, 1'b0, 0, FRAME);
      push_slots(16'hFFFF, 4'b0000, 1'b0, 0, FRAME);
      for (int k = 0; k < 2 * FRAME; k++) begin
         if (k == 6) begin
            load = 1'b1; data_in = 16'hFFFF; dp_in = 4'b0000;
         end
         @(posedge clk); #1;
         load = 1'b0;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL no_tearing[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic seen;
      logic [12:0] exp, obs;
      wait_frame(seen);
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++; $display("FAIL wrap_frame_done: got %b want 1", seen);
      end
      push_slots(16'hFFFF, 4'b0000, 1'b0, 0, FRAME);
      push_slots(16'h0000, 4'b0000, 1'b0, 0, FRAME);
      for (int k = 0; k < 2 * FRAME; k++) begin
         // Position FRAME-1 is the wrap cycle itself.
         if (k == FRAME - 1) begin
            load = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
         end
         @(posedge clk); #1;
         load = 1'b0;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL wrap_load[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_enable();
      logic seen;
      logic [12:0] exp, obs;
      wait_frame(seen);
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++; $display("FAIL enable_frame_done: got %b want 1", seen);
      end
      push_slots(16'h0000, 4'b0000, 1'b0, 0, 6);
      push_dark(4);
      push_slots(16'h9876, 4'b0001, 1'b0, 0, FRAME);
      for (int k = 0; k < 6 + 4 + FRAME; k++) begin
         if (k == 6) enable = 1'b0;
         if (k == 7) begin
            load = 1'b1; data_in = 16'h9876; dp_in = 4'b0001;
         end
         if (k == 10) enable = 1'b1;
         @(posedge clk); #1;
         load = 1'b0;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL enable[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic seen;
      logic [12:0] exp, obs;
      wait_frame(seen);
      n_tests++;
      if (seen !== 1'b1) begin
         n_fail++; $display("FAIL arst_frame_done: got %b want 1", seen);
      end
      push_slots(16'h9876, 4'b0001, 1'b0, 0, 6);
      for (int k = 0; k < 6; k++) begin
         if (k == 5) begin
            load = 1'b1; data_in = 16'h5555; dp_in = 4'b1111;
         end
         @(posedge clk); #1;
         load = 1'b0;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL pre_reset[%0d]: got %b want %b", k, obs, exp);
         end
      end
      #3;
      rst_n = 1'b0;
      #1;
      obs = {frame_done, dig_sel, dp_out, seg_out};
      n_tests++;
      if (obs !== DARK) begin
         n_fail++; $display("FAIL async_reset_immediate: got %b want %b", obs, DARK);
      end
      push_dark(12);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL in_reset[%0d]: got %b want %b", k, obs, exp);
         end
      end
      #2;
      rst_n = 1'b1;
      push_slots(16'h0000, 4'b0000, 1'b0, 0, 2 * FRAME);
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(posedge clk); #1;
         exp = exp_q.pop_front();
         obs = {frame_done, dig_sel, dp_out, seg_out};
         n_tests++;
         if (obs !== exp) begin
            n_fail++; $display("FAIL post_reset[%0d]: got %b want %b", k, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz_blank();
      test_no_tearing();
      test_back_to_back();
      test_enable();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
